// File: rtl/decode_regfile.sv
// Y86-64 SEQ decode / write-back stage: derives register ids from fetch fields and
// holds the 15 x DATA_W program register file with two async reads and two clocked writes.
module decode_regfile #(
  parameter int                 DATA_W   = 64,
  parameter logic [DATA_W-1:0]  RSP_INIT = {DATA_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        icode_i,
  input  logic [3:0]        rA_i,
  input  logic [3:0]        rB_i,
  input  logic              cnd_i,
  input  logic [DATA_W-1:0] valE_i,
  input  logic [DATA_W-1:0] valM_i,
  input  logic              wb_en_i,
  output logic [3:0]        srcA_o,
  output logic [3:0]        srcB_o,
  output logic [3:0]        dstE_o,
  output logic [3:0]        dstM_o,
  output logic [DATA_W-1:0] valA_o,
  output logic [DATA_W-1:0] valB_o,
  input  logic [3:0]        dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  localparam logic [3:0] NREG = 4'hF;
  localparam logic [3:0] RSP  = 4'h4;

  logic [DATA_W-1:0] regs [0:14];
  logic [3:0]        src_a;
  logic [3:0]        src_b;
  logic [3:0]        dst_e;
  logic [3:0]        dst_m;

  function automatic logic [DATA_W-1:0] read_reg(input logic [3:0] id);
    logic [DATA_W-1:0] val;
    if (id == NREG) begin
      val = {DATA_W{1'b0}};
    end else begin
      val = regs[id];
    end
    return val;
  endfunction

  // Register id decode; unused icodes fall through to NREG on every port.
  always_comb begin
    src_a = NREG;
    src_b = NREG;
    dst_e = NREG;
    dst_m = NREG;
    case (icode_i)
      4'h2: begin
        src_a = rA_i;
        if (cnd_i) begin
          dst_e = rB_i;
        end else begin
          dst_e = NREG;
        end
      end
      4'h3: dst_e = rB_i;
      4'h4: begin
        src_a = rA_i;
        src_b = rB_i;
      end
      4'h5: begin
        src_b = rB_i;
        dst_m = rA_i;
      end
      4'h6: begin
        src_a = rA_i;
        src_b = rB_i;
        dst_e = rB_i;
      end
      4'h8: begin
        src_b = RSP;
        dst_e = RSP;
      end
      4'h9: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
      end
      4'hA: begin
        src_a = rA_i;
        src_b = RSP;
        dst_e = RSP;
      end
      4'hB: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
        dst_m = rA_i;
      end
      default: begin
        src_a = NREG;
        src_b = NREG;
        dst_e = NREG;
        dst_m = NREG;
      end
    endcase
  end

  assign srcA_o     = src_a;
  assign srcB_o     = src_b;
  assign dstE_o     = dst_e;
  assign dstM_o     = dst_m;
  assign valA_o     = read_reg(src_a);
  assign valB_o     = read_reg(src_b);
  assign dbg_data_o = read_reg(dbg_addr_i);

  // Write-back; the M port is applied last so it wins a dstE == dstM collision.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 15; i++) begin
      if (rst_i) begin
        regs[i] <= (4'(i) == RSP) ? RSP_INIT : {DATA_W{1'b0}};
      end else if (wb_en_i) begin
        if (dst_e == 4'(i)) begin
          regs[i] <= valE_i;
        end
        if (dst_m == 4'(i)) begin
          regs[i] <= valM_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: reset contents, decode of each test-plan
// instruction, cmov gating, popq collision, commit gating and invalid icodes.
module tb_decode_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic        cnd;
  logic [63:0] val_e;
  logic [63:0] val_m;
  logic        wb_en;
  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic [63:0] val_a;
  logic [63:0] val_b;
  logic [3:0]  dbg_addr;
  logic [63:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  decode_regfile #(.DATA_W(64), .RSP_INIT(64'h200)) dut (
    .clk_i(clk), .rst_i(rst), .icode_i(icode), .rA_i(ra), .rB_i(rb),
    .cnd_i(cnd), .valE_i(val_e), .valM_i(val_m), .wb_en_i(wb_en),
    .srcA_o(src_a), .srcB_o(src_b), .dstE_o(dst_e), .dstM_o(dst_m),
    .valA_o(val_a), .valB_o(val_b), .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    if (!done) begin
      n_err++;
      $error("FAIL timeout: directed sequence did not complete");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; icode = 4'h1; ra = 4'hF; rb = 4'hF; cnd = 1'b0;
    val_e = 64'h0; val_m = 64'h0; wb_en = 1'b0; dbg_addr = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0;

    // reset contents
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check("reset_dbg", dbg_data, (i == 4) ? 64'h200 : 64'h0);
    end

    // irmovq $0x1234, %rdx
    icode = 4'h3; ra = 4'hF; rb = 4'h2; val_e = 64'h1234; wb_en = 1'b1;
    #1;
    check("irmovq_dstE", 64'(dst_e), 64'h2);
    check("irmovq_dstM", 64'(dst_m), 64'hF);
    @(posedge clk); #1;
    icode = 4'h6; ra = 4'h2; rb = 4'h2; wb_en = 1'b0;
    #1;
    check("opq_srcA", 64'(src_a), 64'h2);
    check("opq_srcB", 64'(src_b), 64'h2);
    check("opq_valA", val_a, 64'h1234);
    check("opq_valB", val_b, 64'h1234);

    // cmovXX %rcx, %rbx with cnd false then true
    icode = 4'h2; ra = 4'h1; rb = 4'h3; cnd = 1'b0; val_e = 64'h5; wb_en = 1'b1;
    dbg_addr = 4'h3;
    #1;
    check("cmov_nc_dstE", 64'(dst_e), 64'hF);
    check("cmov_srcA", 64'(src_a), 64'h1);
    @(posedge clk); #1;
    check("cmov_nc_reg3", dbg_data, 64'h0);
    cnd = 1'b1;
    #1;
    check("cmov_c_dstE", 64'(dst_e), 64'h3);
    @(posedge clk); #1;
    check("cmov_c_reg3", dbg_data, 64'h5);
    cnd = 1'b0;

    // popq %rsp: M port wins the collision on reg 4
    icode = 4'hB; ra = 4'h4; rb = 4'hF; val_e = 64'h208; val_m = 64'hABC; wb_en = 1'b1;
    dbg_addr = 4'h4;
    #1;
    check("popq_srcA", 64'(src_a), 64'h4);
    check("popq_srcB", 64'(src_b), 64'h4);
    check("popq_dstE", 64'(dst_e), 64'h4);
    check("popq_dstM", 64'(dst_m), 64'h4);
    check("popq_valA_pre", val_a, 64'h200);
    @(posedge clk); #1;
    check("popq_reg4", dbg_data, 64'hABC);

    // mrmovq into %rdi with commit withheld
    icode = 4'h5; ra = 4'h7; rb = 4'hF; val_m = 64'h9; wb_en = 1'b0; dbg_addr = 4'h7;
    #1;
    check("mrmovq_dstM", 64'(dst_m), 64'h7);
    check("mrmovq_dstE", 64'(dst_e), 64'hF);
    @(posedge clk); #1;
    check("gated_reg7", dbg_data, 64'h0);

    // reset overrides a simultaneous committed write
    wb_en = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wb_en = 1'b0;
    #1;
    check("rst_wr_reg7", dbg_data, 64'h0);
    dbg_addr = 4'h4; #1;
    check("rst_reg4", dbg_data, 64'h200);
    dbg_addr = 4'h2; #1;
    check("rst_reg2", dbg_data, 64'h0);
    dbg_addr = 4'h3; #1;
    check("rst_reg3", dbg_data, 64'h0);

    // seed reg5 so dropped writes would be visible
    icode = 4'h3; ra = 4'hF; rb = 4'h5; val_e = 64'h55; wb_en = 1'b1;
    @(posedge clk); #1;
    dbg_addr = 4'h5; #1;
    check("seed_reg5", dbg_data, 64'h55);

    // jXX and icode D decode to no registers and never write
    icode = 4'h7; ra = 4'h5; rb = 4'h4; val_e = 64'hFFFF; val_m = 64'hEEEE; wb_en = 1'b1;
    cnd = 1'b1;
    #1;
    check("jxx_srcA", 64'(src_a), 64'hF);
    check("jxx_srcB", 64'(src_b), 64'hF);
    check("jxx_dstE", 64'(dst_e), 64'hF);
    check("jxx_dstM", 64'(dst_m), 64'hF);
    check("jxx_valA", val_a, 64'h0);
    @(posedge clk); #1;
    icode = 4'hD;
    #1;
    check("icD_srcA", 64'(src_a), 64'hF);
    check("icD_srcB", 64'(src_b), 64'hF);
    check("icD_dstE", 64'(dst_e), 64'hF);
    check("icD_dstM", 64'(dst_m), 64'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    wb_en = 1'b0;
    dbg_addr = 4'h5; #1;
    check("inv_reg5", dbg_data, 64'h55);
    dbg_addr = 4'h4; #1;
    check("inv_reg4", dbg_data, 64'h200);

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
